game_flow_controller: RTL and testbench

//  Top-level game sequencer: owns game phase (idle/play/hit/level-up/over/win), gates raw

---
 rtl/game_flow_controller_pkg.sv | 27 ++
 rtl/game_flow_controller_if.sv | 29 ++
 rtl/game_flow_controller_frame_timer.sv | 27 ++
 rtl/game_flow_controller.sv | 144 ++++++++++++++
 tb/tb_game_flow_controller.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_flow_controller_pkg.sv
// Game sequencer shared types and defaults.
// Phase encoding plus frame-counter sizing helper.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE_ST,
        PLAY_ST,
        HIT_ST,
        LEVELUP_ST,
        OVER_ST,
        WIN_ST
    } game_state_t;

    localparam int DEF_INVULN_FRAMES     = 60;
    localparam int DEF_LEVELUP_FRAMES    = 90;
    localparam int DEF_TARGETS_PER_LEVEL = 3;
    localparam int DEF_NUM_LEVELS        = 4;

    // Counter must hold the larger of the two frame loads.
    function automatic int frame_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Game controller bus: object/lives inputs and overlay/lives outputs.
// master drives the game inputs, slave is the controller.
interface game_flow_controller_if;
    logic       startOfFrame;
    logic       start_key;
    logic       collision;
    logic       target_hit;
    logic       no_life;
    logic       life_hit;
    logic       lives_reloadN;
    logic       game_active;
    logic       flash_en;
    logic       freeze;
    logic [2:0] level;
    logic       game_over;
    logic       game_win;

    modport master (
        output startOfFrame, start_key, collision, target_hit, no_life,
        input  life_hit, lives_reloadN, game_active, flash_en, freeze,
        input  level, game_over, game_win
    );

    modport slave (
        input  startOfFrame, start_key, collision, target_hit, no_life,
        output life_hit, lives_reloadN, game_active, flash_en, freeze,
        output level, game_over, game_win
    );
endinterface

// File: rtl/game_flow_controller_frame_timer.sv
// Frame countdown shared by the hit and level-up pauses.
// Load wins over decrement; count saturates at zero.
module game_flow_controller_frame_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         sof,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;

    // Load on request, otherwise count frames down to zero.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (sof && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/game_flow_controller.sv
// Game phase sequencer: hit gating, invulnerability and level flow.
// Edge detectors and the phase FSM live here; pauses use frame_timer.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int INVULN_FRAMES     = DEF_INVULN_FRAMES,
    parameter int LEVELUP_FRAMES    = DEF_LEVELUP_FRAMES,
    parameter int TARGETS_PER_LEVEL = DEF_TARGETS_PER_LEVEL,
    parameter int NUM_LEVELS        = DEF_NUM_LEVELS
) (
    input logic             clk,
    input logic             resetN,
    game_flow_controller_if.slave bus
);
    localparam int FW = frame_w(INVULN_FRAMES, LEVELUP_FRAMES);
    localparam logic [FW-1:0] INV_V = FW'(INVULN_FRAMES);
    localparam logic [FW-1:0] LUP_V = FW'(LEVELUP_FRAMES);
    localparam logic [3:0] TGT_LAST = 4'(TARGETS_PER_LEVEL - 1);
    localparam logic [2:0] LVL_LAST = 3'(NUM_LEVELS - 1);

    game_state_t state, state_n;
    logic col_d, tgt_d, start_d;
    logic col_rise, tgt_rise, start_rise;
    logic hit_take, tgt_take, reload;
    logic t_load, t_done;
    logic [FW-1:0] t_val;
    logic [3:0] tcnt;
    logic [2:0] level_q;
    logic life_hit_q, reload_q;
    logic active_q, flash_q, freeze_q, over_q, win_q;

    assign col_rise   = bus.collision  && !col_d;
    assign tgt_rise   = bus.target_hit && !tgt_d;
    assign start_rise = bus.start_key  && !start_d;

    game_flow_controller_frame_timer #(.W(FW)) u_timer (
        .clk      (clk),
        .resetN   (resetN),
        .sof      (bus.startOfFrame),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    // Next phase and the single-cycle actions taken on this cycle's events.
    always_comb begin
        state_n  = state;
        hit_take = 1'b0;
        tgt_take = 1'b0;
        reload   = 1'b0;
        t_load   = 1'b0;
        t_val    = INV_V;
        case (state)
            IDLE_ST, OVER_ST, WIN_ST: begin
                if (start_rise) begin
                    reload  = 1'b1;
                    state_n = PLAY_ST;
                end
            end
            PLAY_ST: begin
                // Ignore stale no_life while the lives reload is in flight.
                if (bus.no_life && reload_q) begin
                    state_n = OVER_ST;
                end else if (col_rise) begin
                    hit_take = 1'b1;
                    t_load   = 1'b1;
                    t_val    = INV_V;
                    state_n  = HIT_ST;
                end else if (tgt_rise) begin
                    tgt_take = 1'b1;
                    if (tcnt == TGT_LAST) begin
                        if (level_q == LVL_LAST) begin
                            state_n = WIN_ST;
                        end else begin
                            t_load  = 1'b1;
                            t_val   = LUP_V;
                            state_n = LEVELUP_ST;
                        end
                    end
                end
            end
            HIT_ST: begin
                if (bus.no_life) state_n = OVER_ST;
                else if (t_done) state_n = PLAY_ST;
            end
            LEVELUP_ST: begin
                if (t_done) state_n = PLAY_ST;
            end
            default: state_n = IDLE_ST;
        endcase
    end

    // Phase register, edge history, level/target counters and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE_ST;
            col_d      <= 1'b0;
            tgt_d      <= 1'b0;
            start_d    <= 1'b0;
            tcnt       <= '0;
            level_q    <= '0;
            life_hit_q <= 1'b0;
            reload_q   <= 1'b1;
            active_q   <= 1'b0;
            flash_q    <= 1'b0;
            freeze_q   <= 1'b1;
            over_q     <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            state      <= state_n;
            col_d      <= bus.collision;
            tgt_d      <= bus.target_hit;
            start_d    <= bus.start_key;
            life_hit_q <= hit_take;
            reload_q   <= !reload;
            if (reload) begin
                tcnt    <= '0;
                level_q <= '0;
            end else if (tgt_take) begin
                if (tcnt == TGT_LAST) begin
                    tcnt <= '0;
                    if (level_q != LVL_LAST) level_q <= level_q + 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
            active_q <= (state_n == PLAY_ST) || (state_n == HIT_ST);
            flash_q  <= (state_n == HIT_ST);
            freeze_q <= (state_n == IDLE_ST) || (state_n == LEVELUP_ST) ||
                        (state_n == OVER_ST) || (state_n == WIN_ST);
            over_q   <= (state_n == OVER_ST);
            win_q    <= (state_n == WIN_ST);
        end
    end

    assign bus.life_hit      = life_hit_q;
    assign bus.lives_reloadN = reload_q;
    assign bus.game_active   = active_q;
    assign bus.flash_en      = flash_q;
    assign bus.freeze        = freeze_q;
    assign bus.level         = level_q;
    assign bus.game_over     = over_q;
    assign bus.game_win      = win_q;
endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller with a small lives counter and phase model.
// Model is compared every cycle; directed steps add literal checks.
module tb_game_flow_controller;
    localparam int INV = 4;
    localparam int LUP = 3;
    localparam int TPL = 2;
    localparam int NLV = 2;

    typedef enum int {M_IDLE, M_PLAY, M_HIT, M_LUP, M_OVER, M_WIN} mph_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int n_hits = 0;
    int fc = 0;

    game_flow_controller_if bus();

    game_flow_controller #(
        .INVULN_FRAMES     (INV),
        .LEVELUP_FRAMES    (LUP),
        .TARGETS_PER_LEVEL (TPL),
        .NUM_LEVELS        (NLV)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Lives counter: 3 lives, reloaded asynchronously by reset or reload pulse.
    logic rl;
    logic [1:0] lives;
    assign rl = resetN & bus.lives_reloadN;
    always_ff @(posedge clk or negedge rl) begin
        if (!rl) lives <= 2'd3;
        else if (bus.life_hit && lives != 0) lives <= lives - 2'd1;
    end
    assign bus.no_life = (lives == 2'd0);

    // Behavioural phase model.
    mph_t m_ph;
    int m_lvl, m_tg, m_fr;
    logic m_hit, m_rl, p_col, p_tgt, p_st;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_ph <= M_IDLE; m_lvl <= 0; m_tg <= 0; m_fr <= 0;
            m_hit <= 0; m_rl <= 1; p_col <= 0; p_tgt <= 0; p_st <= 0;
        end else begin
            p_col <= bus.collision;
            p_tgt <= bus.target_hit;
            p_st  <= bus.start_key;
            m_hit <= 0;
            m_rl  <= 1;
            if (bus.startOfFrame && m_fr > 0) m_fr <= m_fr - 1;
            case (m_ph)
                M_IDLE, M_OVER, M_WIN:
                    if (bus.start_key && !p_st) begin
                        m_ph <= M_PLAY; m_rl <= 0; m_lvl <= 0; m_tg <= 0;
                    end
                M_PLAY:
                    if (bus.no_life && m_rl) m_ph <= M_OVER;
                    else if (bus.collision && !p_col) begin
                        m_hit <= 1; m_fr <= INV; m_ph <= M_HIT;
                    end else if (bus.target_hit && !p_tgt) begin
                        if (m_tg + 1 == TPL) begin
                            m_tg <= 0;
                            if (m_lvl == NLV - 1) m_ph <= M_WIN;
                            else begin
                                m_lvl <= m_lvl + 1; m_fr <= LUP; m_ph <= M_LUP;
                            end
                        end else m_tg <= m_tg + 1;
                    end
                M_HIT:
                    if (bus.no_life) m_ph <= M_OVER;
                    else if (m_fr == 0) m_ph <= M_PLAY;
                M_LUP:
                    if (m_fr == 0) m_ph <= M_PLAY;
                default: m_ph <= M_IDLE;
            endcase
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (bus.life_hit === 1'b1) n_hits++;
        chk("m_life_hit", int'(bus.life_hit), int'(m_hit));
        chk("m_reloadN", int'(bus.lives_reloadN), int'(m_rl));
        chk("m_active", int'(bus.game_active), int'(m_ph == M_PLAY || m_ph == M_HIT));
        chk("m_flash", int'(bus.flash_en), int'(m_ph == M_HIT));
        chk("m_freeze", int'(bus.freeze),
            int'(m_ph == M_IDLE || m_ph == M_LUP || m_ph == M_OVER || m_ph == M_WIN));
        chk("m_level", int'(bus.level), m_lvl);
        chk("m_over", int'(bus.game_over), int'(m_ph == M_OVER));
        chk("m_win", int'(bus.game_win), int'(m_ph == M_WIN));
    end

    // Frame pulse every 8 clocks.
    initial begin
        bus.startOfFrame = 1'b0;
        forever begin
            @(posedge clk); #1;
            fc++;
            bus.startOfFrame = (fc % 8 == 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_play(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (bus.game_active && !bus.flash_en && !bus.freeze) begin
                ok = 1;
                break;
            end
        end
        chk({nm, "_timeout"}, int'(ok), 1);
    endtask

    task automatic start_game();
        bus.start_key = 1; cyc(1);
        chk("start_reloadN", int'(bus.lives_reloadN), 0);
        chk("start_active", int'(bus.game_active), 1);
        chk("start_level", int'(bus.level), 0);
        chk("start_freeze", int'(bus.freeze), 0);
        bus.start_key = 0; cyc(1);
        chk("start_reloadN_end", int'(bus.lives_reloadN), 1);
    endtask

    task automatic pulse_tgt();
        bus.target_hit = 1; cyc(1);
        bus.target_hit = 0; cyc(2);
    endtask

    task automatic do_reset();
        resetN = 0; cyc(2);
        resetN = 1; cyc(1);
    endtask

    int h0;

    initial begin
        bus.start_key = 0; bus.collision = 0; bus.target_hit = 0;
        #23;
        chk("rst_life_hit", int'(bus.life_hit), 0);
        chk("rst_reloadN", int'(bus.lives_reloadN), 1);
        chk("rst_freeze", int'(bus.freeze), 1);
        chk("rst_active", int'(bus.game_active), 0);
        resetN = 1;
        cyc(2);

        // Start and a long-held collision.
        start_game();
        h0 = n_hits;
        bus.collision = 1; cyc(1);
        chk("hit1_pulse", int'(bus.life_hit), 1);
        chk("hit1_flash", int'(bus.flash_en), 1);
        cyc(1);
        chk("hit1_single", int'(bus.life_hit), 0);
        cyc(48);
        chk("held_hits", n_hits - h0, 1);
        chk("held_back_play", int'(bus.flash_en), 0);
        bus.collision = 0; cyc(2);
        bus.collision = 1; cyc(1);
        chk("hit2_pulse", int'(bus.life_hit), 1);
        bus.collision = 0;
        wait_play("hit2");
        chk("two_hits", n_hits - h0, 2);

        // Level flow to a win.
        do_reset();
        start_game();
        pulse_tgt();
        chk("lvl0_one_tgt", int'(bus.level), 0);
        pulse_tgt();
        chk("lup_level", int'(bus.level), 1);
        chk("lup_freeze", int'(bus.freeze), 1);
        wait_play("lup");
        pulse_tgt();
        pulse_tgt();
        chk("win", int'(bus.game_win), 1);
        chk("win_freeze", int'(bus.freeze), 1);
        start_game();

        // Collision and target rise together: target discarded.
        bus.collision = 1; bus.target_hit = 1; cyc(1);
        chk("both_hit", int'(bus.life_hit), 1);
        bus.collision = 0; bus.target_hit = 0;
        wait_play("both");
        pulse_tgt();
        chk("both_no_lup", int'(bus.freeze), 0);
        pulse_tgt();
        chk("both_lup", int'(bus.level), 1);
        wait_play("both_lup");

        // Three hits exhaust lives inside the hit window.
        do_reset();
        start_game();
        for (int k = 0; k < 2; k++) begin
            bus.collision = 1; cyc(1);
            bus.collision = 0;
            wait_play("sep_hit");
        end
        bus.collision = 1; cyc(1);
        chk("hit3_pulse", int'(bus.life_hit), 1);
        bus.collision = 0; cyc(1);
        chk("hit3_not_over", int'(bus.game_over), 0);
        chk("hit3_flash", int'(bus.flash_en), 1);
        cyc(1);
        chk("over", int'(bus.game_over), 1);
        chk("over_freeze", int'(bus.freeze), 1);
        cyc(3);
        start_game();
        cyc(3);
        chk("restart_active", int'(bus.game_active), 1);

        // Asynchronous reset in the middle of a hit countdown.
        bus.collision = 1; cyc(1);
        bus.collision = 0; cyc(5);
        chk("pre_rst_flash", int'(bus.flash_en), 1);
        #2 resetN = 0;
        #1;
        chk("arst_flash", int'(bus.flash_en), 0);
        chk("arst_active", int'(bus.game_active), 0);
        chk("arst_freeze", int'(bus.freeze), 1);
        chk("arst_life_hit", int'(bus.life_hit), 0);
        chk("arst_reloadN", int'(bus.lives_reloadN), 1);
        chk("arst_level", int'(bus.level), 0);
        cyc(3);
        resetN = 1;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
